// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge: FSM states,
// AHB transfer/response codes, the bridge address window and APB select decode.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WWAIT   = 3'd1,
    ST_READ    = 3'd2,
    ST_RENABLE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_WENABLE = 3'd5
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  // Top nibble of HADDR that selects this bridge (0x8000_0000-0x8FFF_FFFF).
  localparam logic [3:0] BRIDGE_BASE = 4'h8;

  localparam logic [3:0] SEL0 = 4'b0001;
  localparam logic [3:0] SEL1 = 4'b0010;
  localparam logic [3:0] SEL2 = 4'b0100;
  localparam logic [3:0] SEL3 = 4'b1000;

  // Each slave owns a 64 MiB slot chosen by HADDR[27:26].
  function automatic logic [3:0] decode_sel(input logic [1:0] slot);
    logic [3:0] sel;
    case (slot)
      2'b00:   sel = SEL0;
      2'b01:   sel = SEL1;
      2'b10:   sel = SEL2;
      default: sel = SEL3;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end: qualifies transfers aimed at the bridge window,
// decodes the APB slave and holds address, direction, select and write data.
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              hwrite_i,
  input  logic              hreadyin_i,
  input  logic              hreadyout_i,
  input  logic [1:0]        htrans_i,
  input  logic [ADDR_W-1:0] haddr_i,
  input  logic [DATA_W-1:0] hwdata_i,
  input  logic              wdata_en_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              write_o,
  output logic [NSLV-1:0]   sel_o,
  output logic [DATA_W-1:0] wdata_o
);

  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [NSLV-1:0]   sel_q;
  logic [DATA_W-1:0] wdata_q;
  logic              active_trans;
  logic              in_window;

  assign active_trans = (htrans_i != HTRANS_IDLE) && (htrans_i != HTRANS_BUSY);
  assign in_window    = (haddr_i[ADDR_W-1 -: 4] == BRIDGE_BASE);
  assign valid_o      = hreadyin_i & hreadyout_i & active_trans & in_window;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i) begin
    // NOTE: these are plain registers, not a memory, so clearing them in
    // reset is cheap and keeps Paddr/Pwdata at zero after reset.
    if (!rst_ni) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else begin
      if (valid_o) begin
        addr_q  <= haddr_i;
        write_q <= hwrite_i;
        sel_q   <= decode_sel(haddr_i[ADDR_W-5 -: 2]);
      end
      // Write data arrives one cycle after its address phase.
      if (wdata_en_i) begin
        wdata_q <= hwdata_i;
      end
    end
  end

  assign addr_o  = addr_q;
  assign write_o = write_q;
  assign sel_o   = sel_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge: one two-phase APB SETUP/ENABLE
// transfer per accepted AHB transfer, with back-to-back transfers allowed.
module ahb2apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 4
) (
  input  logic              clock,
  input  logic              Hresetn,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  output logic [DATA_W-1:0] Hrdata,
  output logic              Hreadyout,
  output logic [1:0]        Hresp,
  input  logic [DATA_W-1:0] Prdata,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite
);

  state_e            state_q, state_d;
  logic              valid;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [NSLV-1:0]   sel_q;
  logic [DATA_W-1:0] wdata_q;
  logic              apb_phase;
  logic              wdata_en;

  ahb_slave_if #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .NSLV  (NSLV)
  ) u_ahb_slave_if (
    .clk_i      (clock),
    .rst_ni     (Hresetn),
    .hwrite_i   (Hwrite),
    .hreadyin_i (Hreadyin),
    .hreadyout_i(Hreadyout),
    .htrans_i   (Htrans),
    .haddr_i    (Haddr),
    .hwdata_i   (Hwdata),
    .wdata_en_i (wdata_en),
    .valid_o    (valid),
    .addr_o     (addr_q),
    .write_o    (write_q),
    .sel_o      (sel_q),
    .wdata_o    (wdata_q)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    apb_phase = 1'b0;
    Penable   = 1'b0;
    Hreadyout = 1'b1;
    wdata_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) state_d = Hwrite ? ST_WWAIT : ST_READ;
      end
      ST_WWAIT: begin
        Hreadyout = 1'b0;
        wdata_en  = 1'b1;
        state_d   = ST_WRITE;
      end
      ST_READ: begin
        apb_phase = 1'b1;
        Hreadyout = 1'b0;
        state_d   = ST_RENABLE;
      end
      ST_WRITE: begin
        apb_phase = 1'b1;
        Hreadyout = 1'b0;
        state_d   = ST_WENABLE;
      end
      ST_RENABLE, ST_WENABLE: begin
        // Completion cycle doubles as the next address phase.
        apb_phase = 1'b1;
        Penable   = 1'b1;
        if (valid) state_d = Hwrite ? ST_WWAIT : ST_READ;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!Hresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  assign Pselx  = apb_phase ? sel_q : '0;
  assign Pwrite = apb_phase & write_q;
  assign Paddr  = addr_q;
  assign Pwdata = wdata_q;
  assign Hrdata = Prdata;
  assign Hresp  = HRESP_OKAY;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed testbench for ahb2apb_bridge: reset abort, single read/write,
// slave decode, ignored transfers and back-to-back transfers.
module tb_ahb2apb_bridge;
  import ahb_apb_pkg::*;

  logic        clock;
  logic        Hresetn;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Hrdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Prdata;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;

  int checks = 0;
  int errors = 0;

  ahb2apb_bridge dut (
    .clock    (clock),
    .Hresetn  (Hresetn),
    .Hwrite   (Hwrite),
    .Hreadyin (Hreadyin),
    .Htrans   (Htrans),
    .Haddr    (Haddr),
    .Hwdata   (Hwdata),
    .Hrdata   (Hrdata),
    .Hreadyout(Hreadyout),
    .Hresp    (Hresp),
    .Prdata   (Prdata),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Pselx    (Pselx),
    .Penable  (Penable),
    .Pwrite   (Pwrite)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    Htrans = HTRANS_IDLE;
    Hwrite = 1'b0;
    Haddr  = 32'h0;
  endtask

  task automatic test_reset();
    Haddr  = 32'h8400_0000;
    Htrans = HTRANS_NONSEQ;
    Hwrite = 1'b1;
    tick();
    checks++; if (Hreadyout !== 1'b0) begin errors++; $display("FAIL rst_midwrite_hready got %b exp 0", Hreadyout); end
    drive_idle();
    Hwdata  = 32'hFFFF_0000;
    Hresetn = 1'b0;
    tick();
    tick();
    checks++; if (Pselx !== 4'b0000) begin errors++; $display("FAIL rst_psel got %b exp 0000", Pselx); end
    checks++; if (Penable !== 1'b0) begin errors++; $display("FAIL rst_penable got %b exp 0", Penable); end
    checks++; if (Hreadyout !== 1'b1) begin errors++; $display("FAIL rst_hready got %b exp 1", Hreadyout); end
    checks++; if (Hresp !== 2'b00) begin errors++; $display("FAIL rst_hresp got %b exp 00", Hresp); end
    checks++; if (Paddr !== 32'h0) begin errors++; $display("FAIL rst_paddr got %h exp 00000000", Paddr); end
    checks++; if (Pwdata !== 32'h0) begin errors++; $display("FAIL rst_pwdata got %h exp 00000000", Pwdata); end
    checks++; if (Pwrite !== 1'b0) begin errors++; $display("FAIL rst_pwrite got %b exp 0", Pwrite); end
    Hresetn = 1'b1;
    tick();
    checks++; if (Pselx !== 4'b0000 || Hreadyout !== 1'b1) begin errors++; $display("FAIL rst_no_resume psel %b hready %b exp 0000/1", Pselx, Hreadyout); end
  endtask

  task automatic test_single_read();
    Haddr  = 32'h8000_0010;
    Htrans = HTRANS_NONSEQ;
    Hwrite = 1'b0;
    Prdata = 32'hDEAD_BEEF;
    tick();
    checks++; if (Pselx !== 4'b0001) begin errors++; $display("FAIL rd_t1_psel got %b exp 0001", Pselx); end
    checks++; if (Paddr !== 32'h8000_0010) begin errors++; $display("FAIL rd_t1_paddr got %h exp 80000010", Paddr); end
    checks++; if (Penable !== 1'b0) begin errors++; $display("FAIL rd_t1_penable got %b exp 0", Penable); end
    checks++; if (Hreadyout !== 1'b0) begin errors++; $display("FAIL rd_t1_hready got %b exp 0", Hreadyout); end
    checks++; if (Pwrite !== 1'b0) begin errors++; $display("FAIL rd_t1_pwrite got %b exp 0", Pwrite); end
    drive_idle();
    tick();
    checks++; if (Penable !== 1'b1) begin errors++; $display("FAIL rd_t2_penable got %b exp 1", Penable); end
    checks++; if (Hreadyout !== 1'b1) begin errors++; $display("FAIL rd_t2_hready got %b exp 1", Hreadyout); end
    checks++; if (Hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_t2_hrdata got %h exp deadbeef", Hrdata); end
    checks++; if (Pselx !== 4'b0001 || Paddr !== 32'h8000_0010) begin errors++; $display("FAIL rd_t2_hold psel %b paddr %h exp 0001/80000010", Pselx, Paddr); end
    tick();
    checks++; if (Pselx !== 4'b0000 || Penable !== 1'b0) begin errors++; $display("FAIL rd_t3_idle psel %b penable %b exp 0000/0", Pselx, Penable); end
  endtask

  task automatic test_single_write(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [3:0] exp_sel);
    Haddr  = addr;
    Htrans = HTRANS_NONSEQ;
    Hwrite = 1'b1;
    tick();
    checks++; if (Hreadyout !== 1'b0 || Pselx !== 4'b0000) begin errors++; $display("FAIL wr_t1_wait @%h hready %b psel %b exp 0/0000", addr, Hreadyout, Pselx); end
    drive_idle();
    Hwdata = data;
    tick();
    Hwdata = 32'h0BAD_0BAD;
    checks++; if (Pselx !== exp_sel) begin errors++; $display("FAIL wr_t2_psel @%h got %b exp %b", addr, Pselx, exp_sel); end
    checks++; if (Pwrite !== 1'b1) begin errors++; $display("FAIL wr_t2_pwrite @%h got %b exp 1", addr, Pwrite); end
    checks++; if (Pwdata !== data) begin errors++; $display("FAIL wr_t2_pwdata @%h got %h exp %h", addr, Pwdata, data); end
    checks++; if (Paddr !== addr) begin errors++; $display("FAIL wr_t2_paddr got %h exp %h", Paddr, addr); end
    checks++; if (Penable !== 1'b0 || Hreadyout !== 1'b0) begin errors++; $display("FAIL wr_t2_setup @%h penable %b hready %b exp 0/0", addr, Penable, Hreadyout); end
    tick();
    checks++; if (Penable !== 1'b1 || Hreadyout !== 1'b1) begin errors++; $display("FAIL wr_t3_enable @%h penable %b hready %b exp 1/1", addr, Penable, Hreadyout); end
    checks++; if (Pselx !== exp_sel || Pwdata !== data || Pwrite !== 1'b1) begin errors++; $display("FAIL wr_t3_hold @%h psel %b pwdata %h pwrite %b exp %b/%h/1", addr, Pselx, Pwdata, Pwrite, exp_sel, data); end
    tick();
    checks++; if (Pselx !== 4'b0000 || Penable !== 1'b0) begin errors++; $display("FAIL wr_t4_idle @%h psel %b penable %b exp 0000/0", addr, Pselx, Penable); end
  endtask

  task automatic test_ignored();
    logic [1:0]  trans_v [4];
    logic [31:0] addr_v  [4];
    logic        ready_v [4];
    trans_v = '{HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ};
    addr_v  = '{32'h8000_0000, 32'h8000_0000, 32'h9000_0000, 32'h8000_0004};
    ready_v = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      Htrans   = trans_v[i];
      Haddr    = addr_v[i];
      Hreadyin = ready_v[i];
      Hwrite   = 1'b0;
      tick();
      checks++; if (Pselx !== 4'b0000 || Penable !== 1'b0) begin errors++; $display("FAIL ign%0d_psel psel %b penable %b exp 0000/0", i, Pselx, Penable); end
      checks++; if (Hreadyout !== 1'b1 || Hresp !== 2'b00) begin errors++; $display("FAIL ign%0d_resp hready %b hresp %b exp 1/00", i, Hreadyout, Hresp); end
    end
    Hreadyin = 1'b1;
    drive_idle();
    tick();
    checks++; if (Pselx !== 4'b0000) begin errors++; $display("FAIL ign_after psel %b exp 0000", Pselx); end
  endtask

  task automatic test_back_to_back();
    Haddr  = 32'h8000_0020;
    Htrans = HTRANS_NONSEQ;
    Hwrite = 1'b0;
    tick();
    drive_idle();
    checks++; if (Pselx !== 4'b0001 || Penable !== 1'b0) begin errors++; $display("FAIL b2b_read1 psel %b penable %b exp 0001/0", Pselx, Penable); end
    tick();
    Prdata = 32'hCAFE_0001;
    #1;
    checks++; if (Penable !== 1'b1 || Hreadyout !== 1'b1 || Paddr !== 32'h8000_0020) begin errors++; $display("FAIL b2b_renable1 penable %b hready %b paddr %h exp 1/1/80000020", Penable, Hreadyout, Paddr); end
    checks++; if (Hrdata !== 32'hCAFE_0001) begin errors++; $display("FAIL b2b_hrdata1 got %h exp cafe0001", Hrdata); end
    Haddr  = 32'h8000_0000;
    Htrans = HTRANS_SEQ;
    tick();
    drive_idle();
    checks++; if (Pselx !== 4'b0001 || Penable !== 1'b0 || Hreadyout !== 1'b0) begin errors++; $display("FAIL b2b_read2 psel %b penable %b hready %b exp 0001/0/0", Pselx, Penable, Hreadyout); end
    checks++; if (Paddr !== 32'h8000_0000) begin errors++; $display("FAIL b2b_read2_paddr got %h exp 80000000", Paddr); end
    tick();
    Prdata = 32'hCAFE_0002;
    #1;
    checks++; if (Penable !== 1'b1 || Hrdata !== 32'hCAFE_0002) begin errors++; $display("FAIL b2b_renable2 penable %b hrdata %h exp 1/cafe0002", Penable, Hrdata); end
    Haddr  = 32'h8C00_0008;
    Htrans = HTRANS_NONSEQ;
    Hwrite = 1'b1;
    tick();
    drive_idle();
    Hwdata = 32'hA5A5_5A5A;
    checks++; if (Pselx !== 4'b0000 || Penable !== 1'b0 || Hreadyout !== 1'b0) begin errors++; $display("FAIL b2b_wwait psel %b penable %b hready %b exp 0000/0/0", Pselx, Penable, Hreadyout); end
    tick();
    checks++; if (Pselx !== 4'b1000 || Pwrite !== 1'b1 || Pwdata !== 32'hA5A5_5A5A || Paddr !== 32'h8C00_0008) begin errors++; $display("FAIL b2b_write psel %b pwrite %b pwdata %h paddr %h exp 1000/1/a5a55a5a/8c000008", Pselx, Pwrite, Pwdata, Paddr); end
    tick();
    checks++; if (Penable !== 1'b1 || Hreadyout !== 1'b1 || Pselx !== 4'b1000) begin errors++; $display("FAIL b2b_wenable penable %b hready %b psel %b exp 1/1/1000", Penable, Hreadyout, Pselx); end
    tick();
    checks++; if (Pselx !== 4'b0000 || Hreadyout !== 1'b1) begin errors++; $display("FAIL b2b_idle psel %b hready %b exp 0000/1", Pselx, Hreadyout); end
  endtask

  initial begin
    Hresetn  = 1'b0;
    Hreadyin = 1'b1;
    Hwdata   = 32'h0;
    Prdata   = 32'h0;
    drive_idle();
    tick();
    tick();
    Hresetn = 1'b1;
    tick();
    test_reset();
    test_single_read();
    test_single_write(32'h8400_0004, 32'h1234_5678, 4'b0010);
    test_single_write(32'h8800_0000, 32'h0000_00C3, 4'b0100);
    test_single_write(32'h8C00_0000, 32'h8765_4321, 4'b1000);
    test_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
